// File: rtl/arbitro_memoria_if.sv
// Bundles both requester ports and the memory-side port of the two-way memory arbiter.
// The arbiter takes the slave view; requesters and the memory model use the master view.
interface arbitro_memoria_if #(
   parameter int ANCHO_DIR = 32,
   parameter int ANCHO_DAT = 32
);
   logic                 req_0, esc_0, gnt_0, val_0;
   logic [ANCHO_DIR-1:0] dir_0;
   logic [ANCHO_DAT-1:0] dat_esc_0, dat_lec_0;
   logic                 req_1, esc_1, gnt_1, val_1;
   logic [ANCHO_DIR-1:0] dir_1;
   logic [ANCHO_DAT-1:0] dat_esc_1, dat_lec_1;
   logic [ANCHO_DIR-1:0] mem_dir;
   logic [ANCHO_DAT-1:0] mem_dat_escritura, mem_dat_lectura;
   logic                 mem_hab_escritura;

   modport slave (
      input  req_0, esc_0, dir_0, dat_esc_0, req_1, esc_1, dir_1, dat_esc_1, mem_dat_lectura,
      output gnt_0, val_0, dat_lec_0, gnt_1, val_1, dat_lec_1,
      output mem_dir, mem_dat_escritura, mem_hab_escritura
   );

   modport master (
      output req_0, esc_0, dir_0, dat_esc_0, req_1, esc_1, dir_1, dat_esc_1, mem_dat_lectura,
      input  gnt_0, val_0, dat_lec_0, gnt_1, val_1, dat_lec_1,
      input  mem_dir, mem_dat_escritura, mem_hab_escritura
   );
endinterface

// File: rtl/arbitro_memoria.sv
// Two-requester memory arbiter with bounded bursts; grant and memory access in the same cycle, read valid one cycle later.
// No backpressure: a losing requester simply holds req until granted; at most one access per cycle.
module arbitro_memoria #(
   parameter int ANCHO_DIR  = 32,
   parameter int ANCHO_DAT  = 32,
   parameter int MAX_RAFAGA = 4
) (
   input logic              clk,
   input logic              reset,
   arbitro_memoria_if.slave bus
);
   typedef enum logic [1:0] {LIBRE = 2'd0, DUENO0 = 2'd1, DUENO1 = 2'd2} estado_t;
   localparam logic [3:0] MAX_CNT = 4'(MAX_RAFAGA);

   estado_t              estado_q, estado_d;
   logic [3:0]           cnt_q, cnt_d, cnt_sat;
   logic                 ultimo_q, ultimo_d;
   logic                 val0_q, val0_d, val1_q, val1_d;
   logic                 gnt0, gnt1, mem_hab;
   logic [ANCHO_DIR-1:0] mem_dir;
   logic [ANCHO_DAT-1:0] mem_dat;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         estado_q <= LIBRE;
         cnt_q    <= 4'd0;
         ultimo_q <= 1'b1;
         val0_q   <= 1'b0;
         val1_q   <= 1'b0;
      end else begin
         estado_q <= estado_d;
         cnt_q    <= cnt_d;
         ultimo_q <= ultimo_d;
         val0_q   <= val0_d;
         val1_q   <= val1_d;
      end
   end

   assign cnt_sat = (cnt_q < MAX_CNT) ? cnt_q + 4'd1 : cnt_q;

   always_comb begin
      estado_d = estado_q;
      cnt_d    = cnt_q;
      ultimo_d = ultimo_q;
      if (gnt0) begin
         estado_d = DUENO0;
         ultimo_d = 1'b0;
         cnt_d    = (estado_q == DUENO0) ? cnt_sat : 4'd1;
      end else if (gnt1) begin
         estado_d = DUENO1;
         ultimo_d = 1'b1;
         cnt_d    = (estado_q == DUENO1) ? cnt_sat : 4'd1;
      end else begin
         estado_d = LIBRE;
         cnt_d    = 4'd0;
      end
      val0_d = gnt0 & ~bus.esc_0;
      val1_d = gnt1 & ~bus.esc_1;
   end

   // The owner keeps the bus until its burst limit is hit with the other side waiting.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      case (estado_q)
         DUENO0: begin
            if (bus.req_0 && ((cnt_q < MAX_CNT) || !bus.req_1)) gnt0 = 1'b1;
            else if (bus.req_1)                                  gnt1 = 1'b1;
         end
         DUENO1: begin
            if (bus.req_1 && ((cnt_q < MAX_CNT) || !bus.req_0)) gnt1 = 1'b1;
            else if (bus.req_0)                                  gnt0 = 1'b1;
         end
         default: begin
            gnt0 = bus.req_0 && (!bus.req_1 || ultimo_q);
            gnt1 = bus.req_1 && (!bus.req_0 || !ultimo_q);
         end
      endcase
      if (!reset) begin
         gnt0 = 1'b0;
         gnt1 = 1'b0;
      end
      mem_dir = '0;
      mem_dat = '0;
      mem_hab = 1'b0;
      if (gnt0) begin
         mem_dir = bus.dir_0;
         mem_dat = bus.dat_esc_0;
         mem_hab = bus.esc_0;
      end else if (gnt1) begin
         mem_dir = bus.dir_1;
         mem_dat = bus.dat_esc_1;
         mem_hab = bus.esc_1;
      end
   end

   assign bus.gnt_0             = gnt0;
   assign bus.gnt_1             = gnt1;
   assign bus.mem_dir           = mem_dir;
   assign bus.mem_dat_escritura = mem_dat;
   assign bus.mem_hab_escritura = mem_hab;
   // Gated so a read caught by reset never shows a valid, even for the sliver before the flop clears.
   assign bus.val_0             = val0_q & reset;
   assign bus.val_1             = val1_q & reset;
   assign bus.dat_lec_0         = bus.mem_dat_lectura;
   assign bus.dat_lec_1         = bus.mem_dat_lectura;
endmodule
